// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-side pipeline controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        StIssue,
        StWait,
        StDrain,
        StHold
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry pc/instr holding register that parks a response while IF/ID is stalled.
module fetch_skid_buffer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            drain,
    input  logic            clear,
    input  logic [XLEN-1:0] load_pc,
    input  logic [31:0]     load_instr,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instr
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            pc_q    <= load_pc;
            instr_q <= load_instr;
        end else if (drain) begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign instr = instr_q;

endmodule

// File: rtl/fetch_pipeline_ctrl.sv
// PC, single-outstanding imem request and IF/ID register with stall/flush/redirect handling.
// Optional saturating perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_pipeline_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_pc,
    input  logic            stall_if_id,
    input  logic            if_id_flush,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc_plus_4,
    output logic [31:0]     if_id_instr,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_drop_cnt
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [31:0]     if_id_instr_q, if_id_instr_d;

    logic            skid_load, skid_drain, skid_clear, skid_valid;
    logic [XLEN-1:0] skid_pc;
    logic [31:0]     skid_instr;
    logic            resp_take;
    logic            drop_evt;

    fetch_skid_buffer #(
        .XLEN (XLEN)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (skid_load),
        .drain      (skid_drain),
        .clear      (skid_clear),
        .load_pc    (pc_q),
        .load_instr (imem_rdata),
        .valid      (skid_valid),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        imem_req   = 1'b0;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;
        resp_take  = 1'b0;
        drop_evt   = 1'b0;

        case (state_q)
            StIssue: begin
                imem_req = !stall_pc && !redirect_valid;
                if (imem_req) state_d = StWait;
            end
            StWait: begin
                if (redirect_valid) begin
                    // A response arriving with the redirect is already stale; nothing left to drain.
                    if (imem_rvalid) begin
                        drop_evt = 1'b1;
                        state_d  = StIssue;
                    end else begin
                        state_d  = StDrain;
                    end
                end else if (imem_rvalid) begin
                    pc_d = pc_q + XLEN'(4);
                    if (stall_if_id) begin
                        skid_load = 1'b1;
                        state_d   = StHold;
                    end else begin
                        resp_take = 1'b1;
                        state_d   = StIssue;
                    end
                end
            end
            StHold: begin
                if (redirect_valid) begin
                    skid_clear = 1'b1;
                    drop_evt   = skid_valid;
                    state_d    = StIssue;
                end else if (!stall_if_id && !if_id_flush && skid_valid) begin
                    skid_drain = 1'b1;
                    state_d    = StIssue;
                end
            end
            StDrain: begin
                if (imem_rvalid) begin
                    drop_evt = 1'b1;
                    state_d  = StIssue;
                end
            end
            default: state_d = StIssue;
        endcase

        if (redirect_valid) pc_d = redirect_pc;
    end

    // Flush/redirect beats hold, hold beats new data, and an idle cycle leaves a bubble.
    always_comb begin
        if_id_valid_d = 1'b0;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = NOP_INSTR;
        if (redirect_valid || if_id_flush) begin
            if_id_valid_d = 1'b0;
        end else if (stall_if_id) begin
            if_id_valid_d = if_id_valid_q;
            if_id_instr_d = if_id_instr_q;
        end else if (resp_take) begin
            if_id_valid_d = 1'b1;
            if_id_pc_d    = pc_q;
            if_id_instr_d = imem_rdata;
        end else if (skid_drain) begin
            if_id_valid_d = 1'b1;
            if_id_pc_d    = skid_pc;
            if_id_instr_d = skid_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIssue;
            pc_q          <= RESET_PC;
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
        end
    end

    assign imem_addr       = pc_q;
    assign if_id_valid     = if_id_valid_q;
    assign if_id_pc        = if_id_pc_q;
    assign if_id_pc_plus_4 = if_id_pc_q + XLEN'(4);
    assign if_id_instr     = if_id_instr_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if ((stall_pc || stall_if_id) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (drop_evt && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_drop_cnt  = drop_cnt_q;
`else
    logic unused_drop_evt;
    assign unused_drop_evt = drop_evt;
    assign perf_stall_cnt  = '0;
    assign perf_drop_cnt   = '0;
`endif

endmodule

// File: tb/tb_fetch_pipeline_ctrl.sv
// Scoreboard bench for fetch_pipeline_ctrl: a latency-configurable memory pushes expected
// fetches on each accepted request; an ID-side monitor pops them as IF/ID is consumed.
module tb_fetch_pipeline_ctrl;
    import fetch_pkg::*;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_entry_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_pc = 1'b0;
    logic        stall_if_id = 1'b0;
    logic        if_id_flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus_4;
    logic [31:0] if_id_instr;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_drop_cnt;

    sb_entry_t   sb_q[$];
    sb_entry_t   mem_e, mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    int          mem_lat = 1;
    logic [31:0] exp_pc = '0;
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    always #5 clk = ~clk;

    fetch_pipeline_ctrl #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_pc        (stall_pc),
        .stall_if_id     (stall_if_id),
        .if_id_flush     (if_id_flush),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .if_id_valid     (if_id_valid),
        .if_id_pc        (if_id_pc),
        .if_id_pc_plus_4 (if_id_pc_plus_4),
        .if_id_instr     (if_id_instr),
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_drop_cnt   (perf_drop_cnt)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'h0010_0093 ^ {a[24:0], 7'h0};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: every accepted request is an expected delivery to ID.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
            mem_busy    <= 1'b0;
            mem_cnt     <= 0;
            mem_addr    <= '0;
        end else begin
            imem_rvalid <= 1'b0;
            if (imem_req) begin
                check_eq("imem_addr", imem_addr, exp_pc);
                mem_e.pc    = imem_addr;
                mem_e.instr = instr_of(imem_addr);
                sb_q.push_back(mem_e);
                exp_pc = exp_pc + 32'd4;
                if (mem_lat <= 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= instr_of(imem_addr);
                end else begin
                    mem_busy <= 1'b1;
                    mem_cnt  <= mem_lat - 1;
                    mem_addr <= imem_addr;
                end
            end else if (mem_busy) begin
                if (mem_cnt <= 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= instr_of(mem_addr);
                    mem_busy    <= 1'b0;
                end else begin
                    mem_cnt <= mem_cnt - 1;
                end
            end
        end
    end

    // ID side: a valid IF/ID entry is consumed when not held, or killed by a flush.
    always @(negedge clk) begin
        if (rst_n && if_id_valid && !redirect_valid && (if_id_flush || !stall_if_id)) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("sb_pc", if_id_pc, mon_e.pc);
                check_eq("sb_instr", if_id_instr, mon_e.instr);
                check_eq("sb_pc_plus_4", if_id_pc_plus_4, mon_e.pc + 32'd4);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_id_flush    = 1'b0;
        stall_if_id    = 1'b0;
        sb_q.delete();
        exp_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input logic [31:0] addr, input int budget, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            sample();
            if (imem_req && imem_addr == addr) found = 1'b1;
        end
        check_eq(tag, 32'(found), 32'd1);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        sb_q.delete();
        exp_pc = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;

        // Reset state, then stall_pc for 4 cycles in ISSUE
        stall_pc = 1'b1;
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            sample();
            check_eq("stall_pc_noreq", 32'(imem_req), 32'd0);
            if (i == 0) begin
                check_eq("rst_valid", 32'(if_id_valid), 32'd0);
                check_eq("rst_pc", if_id_pc, 32'h0);
                check_eq("rst_pc_plus_4", if_id_pc_plus_4, 32'h4);
                check_eq("rst_instr", if_id_instr, NOP_INSTR);
                check_eq("rst_addr", imem_addr, 32'h0);
                check_eq("rst_perf_stall", perf_stall_cnt, 32'h0);
                check_eq("rst_perf_drop", perf_drop_cnt, 32'h0);
            end
            tick();
        end
        stall_pc = 1'b0;
        sample();
        check_eq("perf_stall_4", perf_stall_cnt, PERF_ON ? 32'd4 : 32'd0);
        check_eq("first_req", 32'(imem_req), 32'd1);
        check_eq("first_addr", imem_addr, 32'h0);
        tick();
        sample();
        tick();
        sample();
        check_eq("lat_valid", 32'(if_id_valid), 32'd1);
        check_eq("lat_pc", if_id_pc, 32'h0);
        check_eq("lat_pc_plus_4", if_id_pc_plus_4, 32'h4);

        // stall_if_id for 3 cycles across the response for 0x8
        tick();
        wait_req(32'h8, 10, "req_0x8");
        tick();
        stall_if_id = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            check_eq("hold_noreq", 32'(imem_req), 32'd0);
            tick();
        end
        stall_if_id = 1'b0;
        sample();
        check_eq("hold_not_early", 32'(if_id_valid), 32'd0);
        tick();
        sample();
        check_eq("skid_release_valid", 32'(if_id_valid), 32'd1);
        check_eq("skid_release_pc", if_id_pc, 32'h8);
        tick();
        sample();
        check_eq("skid_no_dup", 32'(if_id_valid), 32'd0);

        // Redirect to 0x100 while waiting on a slow response for 0x10
        mem_lat = 3;
        reset_dut();
        wait_req(32'h10, 100, "req_0x10");
        tick();
        do_redirect(32'h100);
        sample();
        check_eq("redir_bubble_valid", 32'(if_id_valid), 32'd0);
        check_eq("redir_bubble_instr", if_id_instr, NOP_INSTR);
        wait_req(32'h100, 20, "req_redirect");
        repeat (6) tick();
        sample();
        check_eq("perf_drop_1", perf_drop_cnt, PERF_ON ? 32'd1 : 32'd0);
        check_eq("perf_stall_0", perf_stall_cnt, 32'd0);

        // Flush and stall together on a valid IF/ID entry
        mem_lat = 1;
        reset_dut();
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            sample();
            if (imem_rvalid) seen = 1'b1;
        end
        check_eq("rvalid_seen", 32'(seen), 32'd1);
        tick();
        if_id_flush = 1'b1;
        stall_if_id = 1'b1;
        sample();
        check_eq("pre_flush_valid", 32'(if_id_valid), 32'd1);
        tick();
        if_id_flush = 1'b0;
        stall_if_id = 1'b0;
        sample();
        check_eq("flush_stall_valid", 32'(if_id_valid), 32'd0);
        check_eq("flush_stall_instr", if_id_instr, NOP_INSTR);

        // PC wrap at the top of the address space
        tick();
        do_redirect(32'hFFFF_FFFC);
        wait_req(32'hFFFF_FFFC, 10, "req_wrap");
        tick();
        sample();
        tick();
        sample();
        check_eq("wrap_valid", 32'(if_id_valid), 32'd1);
        check_eq("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
        check_eq("wrap_pc_plus_4", if_id_pc_plus_4, 32'h0);
        check_eq("wrap_next_req", 32'(imem_req), 32'd1);
        check_eq("wrap_next_addr", imem_addr, 32'h0);

        // Free-run, then quiesce: every issued fetch must have reached ID
        repeat (12) tick();
        stall_pc = 1'b1;
        repeat (8) tick();
        sample();
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
